// File: rtl/csr_timer_bank_pkg.sv
// Shared definitions for the CSR timer bank: register offsets, TCFG fields,
// channel FSM encodings and the masked-write merge helper.
package csr_timer_bank_pkg;

   // Offsets within a channel group (BASE+4i+off)
   localparam logic [1:0] OFF_TCFG  = 2'd0;
   localparam logic [1:0] OFF_TVAL  = 2'd1;
   localparam logic [1:0] OFF_TICLR = 2'd2;
   localparam logic [1:0] OFF_RSVD  = 2'd3;

   // Offsets within the global group (BASE+4N+off)
   localparam logic [1:0] OFF_GIE   = 2'd0;
   localparam logic [1:0] OFF_GPEND = 2'd1;
   localparam logic [1:0] OFF_SCLO  = 2'd2;
   localparam logic [1:0] OFF_SCHI  = 2'd3;

   localparam int TCFG_EN        = 0;
   localparam int TCFG_PERIODIC  = 1;
   localparam int TCFG_INITV_LSB = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef struct packed {
      logic       hit;
      logic       glob;
      logic [2:0] chan;
      logic [1:0] sub;
   } csr_dec_t;

   function automatic logic [31:0] csr_merge(input logic [31:0] wmask,
                                             input logic [31:0] wvalue,
                                             input logic [31:0] old);
      return (wmask & wvalue) | (~wmask & old);
   endfunction

endpackage

// File: rtl/csr_timer_chan.sv
// One countdown timer channel: TCFG register, counter, IDLE/RUN/DONE FSM and
// the sticky pending flag.
module csr_timer_chan
   import csr_timer_bank_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             tcfg_we,
   input  logic             ticlr_we,
   input  logic [31:0]      csr_wmask,
   input  logic [31:0]      csr_wvalue,
   output logic [CNT_W-1:0] tcfg,
   output logic [CNT_W-1:0] count,
   output logic             pending
);

   logic [1:0]       state;
   logic [31:0]      tcfg_merged;
   logic [CNT_W-1:0] tcfg_next;
   logic [CNT_W-1:0] reload_next;
   logic [CNT_W-1:0] reload_cur;
   logic             expire;
   logic             clr_req;
   logic             unused_hi;

   assign tcfg_merged = csr_merge(csr_wmask, csr_wvalue, 32'(tcfg));
   assign tcfg_next   = tcfg_merged[CNT_W-1:0];
   assign unused_hi   = &{1'b0, tcfg_merged};
   assign reload_next = {tcfg_next[CNT_W-1:TCFG_INITV_LSB], 2'b00};
   assign reload_cur  = {tcfg[CNT_W-1:TCFG_INITV_LSB], 2'b00};

   // A TCFG write in the expiry cycle restarts the channel instead of firing
   assign expire  = (state == ST_RUN) && (count == '0) && !tcfg_we;
   assign clr_req = ticlr_we && csr_wmask[0] && csr_wvalue[0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tcfg  <= '0;
         count <= '1;
         state <= ST_IDLE;
      end else if (tcfg_we) begin
         tcfg <= tcfg_next;
         if (tcfg_next[TCFG_EN]) begin
            count <= reload_next;
            state <= ST_RUN;
         end else begin
            state <= ST_IDLE;
         end
      end else begin
         case (state)
            ST_RUN: begin
               if (count != '0) begin
                  count <= count - CNT_W'(1);
               end else if (tcfg[TCFG_PERIODIC]) begin
                  count <= reload_cur;
               end else begin
                  count <= '1;
                  state <= ST_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pending <= 1'b0;
      end else if (expire) begin
         pending <= 1'b1;
      end else if (clr_req) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/csr_timer_bank.sv
// Multi-channel timer/interrupt CSR bank: address decode, global interrupt
// enable, free-running stable counter, combinational read mux and IRQ OR.
module csr_timer_bank
   import csr_timer_bank_pkg::*;
#(
   parameter int          NUM_TIMERS = 2,
   parameter int          CNT_W      = 32,
   parameter int          SC_W       = 64,
   parameter logic [13:0] CSR_BASE   = 14'h100
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  csr_re,
   input  logic [13:0]           csr_num,
   output logic [31:0]           csr_rvalue,
   output logic                  csr_hit,
   input  logic                  csr_we,
   input  logic [31:0]           csr_wmask,
   input  logic [31:0]           csr_wvalue,
   output logic [NUM_TIMERS-1:0] timer_int,
   output logic                  irq_any
);

   localparam logic [13:0] BANK_SIZE = 14'(4 * NUM_TIMERS + 4);

   csr_dec_t              dec;
   logic [13:0]           off;
   logic                  in_bank;
   logic                  chan_we;
   logic                  gie_we;
   logic [31:0]           gie_merged;
   logic [NUM_TIMERS-1:0] gie;
   logic [NUM_TIMERS-1:0] pend;
   logic [NUM_TIMERS-1:0] tcfg_we;
   logic [NUM_TIMERS-1:0] ticlr_we;
   logic [CNT_W-1:0]      tcfg_arr [NUM_TIMERS];
   logic [CNT_W-1:0]      cnt_arr  [NUM_TIMERS];
   logic [CNT_W-1:0]      sel_tcfg;
   logic [CNT_W-1:0]      sel_cnt;
   logic [SC_W-1:0]       sc_q;
   logic [31:0]           rdata;
   logic                  unused_gie_hi;

   assign off     = csr_num - CSR_BASE;
   assign in_bank = (csr_num >= CSR_BASE) && (off < BANK_SIZE);

   always_comb begin
      dec      = '0;
      dec.chan = off[4:2];
      dec.sub  = off[1:0];
      if (in_bank) begin
         if (off[13:2] == 12'(NUM_TIMERS)) begin
            dec.glob = 1'b1;
            dec.hit  = 1'b1;
         end else begin
            dec.hit  = (off[1:0] != OFF_RSVD);
         end
      end
   end

   assign csr_hit = dec.hit;
   assign chan_we = csr_we && dec.hit && !dec.glob;
   assign gie_we  = csr_we && dec.hit && dec.glob && (dec.sub == OFF_GIE);

   for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
      assign tcfg_we[i]  = chan_we && (dec.chan == 3'(i)) && (dec.sub == OFF_TCFG);
      assign ticlr_we[i] = chan_we && (dec.chan == 3'(i)) && (dec.sub == OFF_TICLR);

      csr_timer_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk        (clk),
         .resetn     (resetn),
         .tcfg_we    (tcfg_we[i]),
         .ticlr_we   (ticlr_we[i]),
         .csr_wmask  (csr_wmask),
         .csr_wvalue (csr_wvalue),
         .tcfg       (tcfg_arr[i]),
         .count      (cnt_arr[i]),
         .pending    (pend[i])
      );
   end

   assign gie_merged    = csr_merge(csr_wmask, csr_wvalue, 32'(gie));
   assign unused_gie_hi = &{1'b0, gie_merged};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         gie <= '0;
      end else if (gie_we) begin
         gie <= gie_merged[NUM_TIMERS-1:0];
      end
   end

   // Stable counter wraps naturally from all-ones to zero
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sc_q <= '0;
      end else begin
         sc_q <= sc_q + SC_W'(1);
      end
   end

   always_comb begin
      sel_tcfg = '0;
      sel_cnt  = '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         if (dec.chan == 3'(i)) begin
            sel_tcfg = tcfg_arr[i];
            sel_cnt  = cnt_arr[i];
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (dec.glob) begin
         case (dec.sub)
            OFF_GIE:   rdata = 32'(gie);
            OFF_GPEND: rdata = 32'(pend);
            OFF_SCLO:  rdata = sc_q[31:0];
            default:   rdata = 32'(sc_q[SC_W-1:32]);
         endcase
      end else begin
         case (dec.sub)
            OFF_TCFG: rdata = 32'(sel_tcfg);
            OFF_TVAL: rdata = 32'(sel_cnt);
            default:  rdata = '0;
         endcase
      end
   end

   assign csr_rvalue = (csr_re && dec.hit) ? rdata : 32'h0;

   assign timer_int = pend & gie;
   assign irq_any   = |timer_int;

endmodule
